// File: rtl/debug_display_scheduler.sv
// debug_display_scheduler
// Multiplexes four 32-bit MCU debug sources onto six hex digits across
// eight pages. Pages advance on a debounced push-button press or on an
// auto-rotate timer. A snapshot of the sources is either refreshed every
// cycle (live) or held (frozen) so bus values stay readable.
//
// Page p shows snapshot[p/2]: even pages the low 24 bits, odd pages the
// top 8 bits. dots = {frozen, 2'b00, page}.
//
// Optional feature (macro DEBUG_TRIGGER_EN): an address trigger. A bus
// transfer to trig_addr sets a sticky trig_hit. trig_hit freezes the
// snapshot right after the hitting transfer has been captured.

module debug_display_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ROTATE_CYCLES   = 100000000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DEBUG_TRIGGER_EN
    input  logic [31:0] trig_addr,
    input  logic        trig_clear,
    output logic        trig_hit,
`endif
    input  logic        key_next_n,
    input  logic        auto_mode,
    input  logic        freeze,
    input  logic        mem_strobe,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] src3,
    output logic [2:0]  page,
    output logic [23:0] display_data,
    output logic [5:0]  dots,
    output logic        page_changed
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam int ROT_W = (ROTATE_CYCLES > 2) ? $clog2(ROTATE_CYCLES) : 1;
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_CYCLES - 1);

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_HELD         = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

    logic             key_sync1_r;
    logic             key_sync2_r;
    logic             key_s;
    db_state_t        db_state_r;
    db_state_t        db_state_nxt_s;
    logic [DEB_W-1:0] deb_cnt_r;
    logic [DEB_W-1:0] deb_cnt_nxt_s;
    logic             press_s;
    logic [ROT_W-1:0] rot_cnt_r;
    logic             rotate_s;
    logic [2:0]       page_r;
    logic             page_changed_r;
    logic             frozen_s;
    logic [31:0]      snap0_r;
    logic [31:0]      snap1_r;
    logic [31:0]      snap2_r;
    logic [31:0]      snap3_r;
    logic [31:0]      snap_sel_s;
    logic [23:0]      disp_nxt_s;
    logic [23:0]      display_data_r;
    logic [5:0]       dots_r;

    // Bring the asynchronous button into the clk domain; idle level is released (high).
    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync1_r <= 1'b1;
            key_sync2_r <= 1'b1;
        end else begin
            key_sync1_r <= key_next_n;
            key_sync2_r <= key_sync1_r;
        end
    end

    assign key_s = ~key_sync2_r;

    // Debouncer state and stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_state_r <= DB_IDLE;
            deb_cnt_r  <= '0;
        end else begin
            db_state_r <= db_state_nxt_s;
            deb_cnt_r  <= deb_cnt_nxt_s;
        end
    end

    // Debouncer next state: a level must stay put for DEBOUNCE_CYCLES to be accepted.
    always_comb begin
        db_state_nxt_s = db_state_r;
        deb_cnt_nxt_s  = deb_cnt_r;
        press_s        = 1'b0;
        case (db_state_r)
            DB_IDLE: begin
                deb_cnt_nxt_s = '0;
                if (key_s) begin
                    db_state_nxt_s = DB_PRESS_WAIT;
                end else begin
                    db_state_nxt_s = DB_IDLE;
                end
            end
            DB_PRESS_WAIT: begin
                if (!key_s) begin
                    db_state_nxt_s = DB_IDLE;
                    deb_cnt_nxt_s  = '0;
                end else if (deb_cnt_r == DEB_LAST) begin
                    db_state_nxt_s = DB_HELD;
                    deb_cnt_nxt_s  = '0;
                    press_s        = 1'b1;
                end else begin
                    deb_cnt_nxt_s  = deb_cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
                end
            end
            DB_HELD: begin
                deb_cnt_nxt_s = '0;
                if (!key_s) begin
                    db_state_nxt_s = DB_RELEASE_WAIT;
                end else begin
                    db_state_nxt_s = DB_HELD;
                end
            end
            DB_RELEASE_WAIT: begin
                if (key_s) begin
                    db_state_nxt_s = DB_HELD;
                    deb_cnt_nxt_s  = '0;
                end else if (deb_cnt_r == DEB_LAST) begin
                    db_state_nxt_s = DB_IDLE;
                    deb_cnt_nxt_s  = '0;
                end else begin
                    deb_cnt_nxt_s  = deb_cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                db_state_nxt_s = DB_IDLE;
                deb_cnt_nxt_s  = '0;
            end
        endcase
    end

    assign rotate_s = auto_mode && (rot_cnt_r == ROT_LAST);

    // Auto-rotate timer; a manual press restarts the period so the user gets a full page dwell.
    always_ff @(posedge clk) begin
        if (reset) begin
            rot_cnt_r <= '0;
        end else if (!auto_mode || press_s) begin
            rot_cnt_r <= '0;
        end else if (rotate_s) begin
            rot_cnt_r <= '0;
        end else begin
            rot_cnt_r <= rot_cnt_r + {{(ROT_W-1){1'b0}}, 1'b1};
        end
    end

    // Page advance; a coincident press and rotate count as a single step.
    always_ff @(posedge clk) begin
        if (reset) begin
            page_r         <= 3'd0;
            page_changed_r <= 1'b0;
        end else if (press_s || rotate_s) begin
            page_r         <= page_r + 3'd1;
            page_changed_r <= 1'b1;
        end else begin
            page_changed_r <= 1'b0;
        end
    end

`ifdef DEBUG_TRIGGER_EN
    logic trig_hit_r;

    // Sticky address trigger; an explicit clear beats a simultaneous hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_hit_r <= 1'b0;
        end else if (trig_clear) begin
            trig_hit_r <= 1'b0;
        end else if (mem_strobe && (src1 == trig_addr)) begin
            trig_hit_r <= 1'b1;
        end else begin
            trig_hit_r <= trig_hit_r;
        end
    end

    assign trig_hit = trig_hit_r;
    // trig_hit is still 0 in the hit cycle, so that transfer lands in the snapshot.
    assign frozen_s = freeze | trig_hit_r;
`else
    logic unused_mem_strobe_s;

    assign unused_mem_strobe_s = mem_strobe;
    assign frozen_s            = freeze;
`endif

    // Source snapshot: refreshed every cycle while live, held while frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap0_r <= 32'h0000_0000;
            snap1_r <= 32'h0000_0000;
            snap2_r <= 32'h0000_0000;
            snap3_r <= 32'h0000_0000;
        end else if (!frozen_s) begin
            snap0_r <= src0;
            snap1_r <= src1;
            snap2_r <= src2;
            snap3_r <= src3;
        end else begin
            snap0_r <= snap0_r;
            snap1_r <= snap1_r;
            snap2_r <= snap2_r;
            snap3_r <= snap3_r;
        end
    end

    // Page-to-digits mapping: page[2:1] picks the source, page[0] picks the half.
    always_comb begin
        snap_sel_s = 32'h0000_0000;
        disp_nxt_s = 24'h00_0000;
        case (page_r[2:1])
            2'd0:    snap_sel_s = snap0_r;
            2'd1:    snap_sel_s = snap1_r;
            2'd2:    snap_sel_s = snap2_r;
            2'd3:    snap_sel_s = snap3_r;
            default: snap_sel_s = 32'h0000_0000;
        endcase
        if (page_r[0]) begin
            disp_nxt_s = {16'h0000, snap_sel_s[31:24]};
        end else begin
            disp_nxt_s = snap_sel_s[23:0];
        end
    end

    // Registered digit and dot outputs toward the hex decoders.
    always_ff @(posedge clk) begin
        if (reset) begin
            display_data_r <= 24'h00_0000;
            dots_r         <= 6'b00_0000;
        end else begin
            display_data_r <= disp_nxt_s;
            dots_r         <= {frozen_s, 2'b00, page_r};
        end
    end

    assign page         = page_r;
    assign page_changed = page_changed_r;
    assign display_data = display_data_r;
    assign dots         = dots_r;

endmodule

// File: tb/tb_debug_display_scheduler.sv
// Bench for debug_display_scheduler: directed scenarios followed by a
// randomized phase, every cycle compared against a run-length reference model.

module tb_debug_display_scheduler;

    localparam int DEB = 4;
    localparam int ROT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_next_n;
    logic        auto_mode;
    logic        freeze;
    logic        mem_strobe;
    logic [31:0] src0, src1, src2, src3;
    logic [2:0]  page;
    logic [23:0] display_data;
    logic [5:0]  dots;
    logic        page_changed;
`ifdef DEBUG_TRIGGER_EN
    logic [31:0] trig_addr;
    logic        trig_clear;
    logic        trig_hit;
`endif

    int checks = 0;
    int errors = 0;
    int nchg   = 0;

    // reference model state
    logic        m_s1, m_s2;
    logic        m_acc;
    int          m_run;
    int          m_age;
    logic [2:0]  m_page;
    logic        m_chg;
    logic [31:0] m_snap [4];
    logic [23:0] m_disp;
    logic [5:0]  m_dots;
    logic        m_trig;

    always #5 clk = ~clk;

    debug_display_scheduler #(.DEBOUNCE_CYCLES(DEB), .ROTATE_CYCLES(ROT)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef DEBUG_TRIGGER_EN
        .trig_addr    (trig_addr),
        .trig_clear   (trig_clear),
        .trig_hit     (trig_hit),
`endif
        .key_next_n   (key_next_n),
        .auto_mode    (auto_mode),
        .freeze       (freeze),
        .mem_strobe   (mem_strobe),
        .src0         (src0),
        .src1         (src1),
        .src2         (src2),
        .src3         (src3),
        .page         (page),
        .display_data (display_data),
        .dots         (dots),
        .page_changed (page_changed)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model, one clock edge. Debounce is a run-length rule: the key
    // level is accepted after it differs from the accepted level for DEB+1
    // consecutive samples (one to notice, DEB to confirm).
    task automatic model_update();
        logic [31:0] sel;
        logic        frozen;
        logic        key;
        logic        press;
        logic        rotate;
        if (reset) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_acc = 1'b0; m_run = 0; m_age = 0;
            m_page = 3'd0; m_chg = 1'b0; m_disp = 24'h0; m_dots = 6'h0; m_trig = 1'b0;
            for (int i = 0; i < 4; i++) m_snap[i] = 32'h0;
        end else begin
            frozen = freeze;
`ifdef DEBUG_TRIGGER_EN
            frozen = freeze | m_trig;
`endif
            sel    = m_snap[int'(m_page) / 2];
            m_disp = (int'(m_page) % 2 == 1) ? {16'h0000, sel[31:24]} : sel[23:0];
            m_dots = {frozen, 2'b00, m_page};

            key   = !m_s2;
            press = 1'b0;
            if (key != m_acc) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_acc = key;
                    m_run = 0;
                    press = key;
                end
            end else begin
                m_run = 0;
            end

            rotate = auto_mode && (m_age % ROT == ROT - 1);
            if (!auto_mode || press) m_age = 0;
            else m_age++;

            m_chg = press || rotate;
            if (m_chg) m_page = 3'((int'(m_page) + 1) % 8);

            if (!frozen) begin
                m_snap[0] = src0; m_snap[1] = src1; m_snap[2] = src2; m_snap[3] = src3;
            end
`ifdef DEBUG_TRIGGER_EN
            if (trig_clear) m_trig = 1'b0;
            else if (mem_strobe && src1 == trig_addr) m_trig = 1'b1;
`endif
            m_s2 = m_s1;
            m_s1 = key_next_n;
        end
    endtask

    task automatic compare_all();
        check_eq("page", 32'(page), 32'(m_page));
        check_eq("display", 32'(display_data), 32'(m_disp));
        check_eq("dots", 32'(dots), 32'(m_dots));
        check_eq("page_changed", 32'(page_changed), 32'(m_chg));
`ifdef DEBUG_TRIGGER_EN
        check_eq("trig_hit", 32'(trig_hit), 32'(m_trig));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (page_changed) nchg++;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_key();
        key_next_n = 1'b0;
        ticks(10);
        key_next_n = 1'b1;
        ticks(10);
    endtask

    initial begin
        int guard;
        int key_left;
        reset = 1'b1; key_next_n = 1'b1; auto_mode = 1'b0; freeze = 1'b0; mem_strobe = 1'b0;
        src0 = 32'h0000_0011; src1 = 32'hDEAD_BEEF; src2 = 32'h0055_AA77; src3 = 32'h3333_3333;
`ifdef DEBUG_TRIGGER_EN
        trig_addr = 32'hFFFF_FFFF; trig_clear = 1'b0;
`endif
        @(negedge clk);
        ticks(2);
        check_eq("rst_page", 32'(page), 32'd0);
        check_eq("rst_display", 32'(display_data), 32'd0);
        check_eq("rst_dots", 32'(dots), 32'd0);
        reset = 1'b0;

        // long press and release: one advance, one pulse
        nchg = 0;
        key_next_n = 1'b0; ticks(20);
        key_next_n = 1'b1; ticks(20);
        check_eq("press_page", 32'(page), 32'd1);
        check_eq("press_pulses", 32'(nchg), 32'd1);

        // glitch then bounce: exactly one advance
        nchg = 0;
        key_next_n = 1'b0; ticks(3);
        key_next_n = 1'b1; ticks(10);
        key_next_n = 1'b0; ticks(2);
        key_next_n = 1'b1; ticks(1);
        key_next_n = 1'b0; ticks(10);
        key_next_n = 1'b1; ticks(10);
        check_eq("bounce_pulses", 32'(nchg), 32'd1);
        check_eq("bounce_page", 32'(page), 32'd2);
        check_eq("page2_low", 32'(display_data), 32'h00AD_BEEF);

        press_key();
        check_eq("page3_high", 32'(display_data), 32'h0000_00DE);
        freeze = 1'b1;
        src1 = 32'h1234_5678;
        ticks(4);
        check_eq("frozen_display", 32'(display_data), 32'h0000_00DE);
        check_eq("frozen_dot", 32'(dots[5]), 32'd1);
        freeze = 1'b0;
        ticks(3);
        check_eq("live_again", 32'(display_data), 32'h0000_0012);

        // auto rotation including wrap, then park on page 5
        auto_mode = 1'b1;
        ticks(70);
        guard = 0;
        while (page != 3'd5 && guard < 40) begin
            tick();
            guard++;
        end
        check_eq("reach_page5", 32'(page), 32'd5);
        auto_mode = 1'b0;
        key_next_n = 1'b0;
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midpress_page", 32'(page), 32'd0);
        check_eq("midpress_display", 32'(display_data), 32'd0);
        check_eq("midpress_dots", 32'(dots), 32'd0);
        ticks(3);
        key_next_n = 1'b1;
        ticks(12);
        check_eq("no_press_after_rst", 32'(page), 32'd0);

`ifdef DEBUG_TRIGGER_EN
        trig_addr = 32'h0000_1000;
        src1 = 32'h0000_1000; src2 = 32'h0000_CAFE; mem_strobe = 1'b1;
        tick();
        mem_strobe = 1'b0; src1 = 32'h0BAD_0BAD; src2 = 32'h0055_AA77;
        tick();
        check_eq("trig_set", 32'(trig_hit), 32'd1);
        for (int i = 0; i < 4; i++) press_key();
        check_eq("trig_page", 32'(page), 32'd4);
        check_eq("trig_display", 32'(display_data), 32'h0000_CAFE);
        trig_clear = 1'b1;
        tick();
        trig_clear = 1'b0;
        ticks(3);
        check_eq("trig_cleared", 32'(trig_hit), 32'd0);
        check_eq("trig_live", 32'(display_data), 32'h0055_AA77);
        trig_addr = $urandom();
`endif

        // randomized phase
        key_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (key_left == 0) begin
                key_next_n = ($urandom_range(0, 1) == 1);
                key_left   = int'($urandom_range(1, 9));
            end
            key_left--;
            if ($urandom_range(0, 39) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 29) == 0) freeze = ~freeze;
            mem_strobe = ($urandom_range(0, 7) == 0);
            src0 = $urandom(); src1 = $urandom(); src2 = $urandom(); src3 = $urandom();
`ifdef DEBUG_TRIGGER_EN
            if ($urandom_range(0, 5) == 0) src1 = trig_addr;
            trig_clear = ($urandom_range(0, 19) == 0);
`endif
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
